// File: rtl/sdes_pkg.sv
// rtl/sdes_pkg.sv - shared S-DES types, permutation tables, S-boxes and round functions
//
// Purpose : engine state encoding plus the P10/P8/P4/IP/IP^-1/E-P tables,
//           S-boxes S0/S1, subkey derivation and the fK round function.
// Ports   : none (package).
// Bit order: every vector is declared [0:N-1] so index 0 is the MSB, the same
//           numbering the classic tables use. The tables below hold 0-based
//           positions (textbook values minus one).
package sdes_pkg;

  typedef enum logic [1:0] {IDLE, R1, R2, DONE} state_t;

  localparam logic [3:0] P10_T [10] = '{4'd2, 4'd4, 4'd1, 4'd6, 4'd3, 4'd9, 4'd0, 4'd8, 4'd7, 4'd5};
  localparam logic [3:0] P8_T  [8]  = '{4'd5, 4'd2, 4'd6, 4'd3, 4'd7, 4'd4, 4'd9, 4'd8};
  localparam logic [1:0] P4_T  [4]  = '{2'd1, 2'd3, 2'd2, 2'd0};
  localparam logic [2:0] IP_T  [8]  = '{3'd1, 3'd5, 3'd2, 3'd0, 3'd3, 3'd7, 3'd4, 3'd6};
  localparam logic [2:0] IPI_T [8]  = '{3'd3, 3'd0, 3'd2, 3'd4, 3'd6, 3'd1, 3'd7, 3'd5};
  localparam logic [1:0] EP_T  [8]  = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd3, 2'd0};

  // S-boxes indexed by {row, col}: row = outer bits, col = inner bits.
  localparam logic [1:0] S0_T [16] = '{2'd1, 2'd0, 2'd3, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0,
                                       2'd0, 2'd2, 2'd1, 2'd3, 2'd3, 2'd1, 2'd3, 2'd2};
  localparam logic [1:0] S1_T [16] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd1, 2'd3,
                                       2'd3, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd3};

  function automatic logic [0:9] sdes_p10(input logic [0:9] k);
    logic [0:9] r;
    for (int i = 0; i < 10; i++) r[4'(i)] = k[P10_T[4'(i)]];
    return r;
  endfunction

  function automatic logic [0:7] sdes_p8(input logic [0:9] k);
    logic [0:7] r;
    for (int i = 0; i < 8; i++) r[3'(i)] = k[P8_T[3'(i)]];
    return r;
  endfunction

  // Circular left shift of each 5-bit half by one position.
  function automatic logic [0:9] sdes_ls1(input logic [0:9] v);
    return {v[1:4], v[0], v[6:9], v[5]};
  endfunction

  function automatic logic [0:7] sdes_k1(input logic [0:9] key);
    return sdes_p8(sdes_ls1(sdes_p10(key)));
  endfunction

  // K2 takes the K1 shift result and shifts two more places.
  function automatic logic [0:7] sdes_k2(input logic [0:9] key);
    return sdes_p8(sdes_ls1(sdes_ls1(sdes_ls1(sdes_p10(key)))));
  endfunction

  function automatic logic [0:7] sdes_ip(input logic [0:7] d);
    logic [0:7] r;
    for (int i = 0; i < 8; i++) r[3'(i)] = d[IP_T[3'(i)]];
    return r;
  endfunction

  function automatic logic [0:7] sdes_ip_inv(input logic [0:7] d);
    logic [0:7] r;
    for (int i = 0; i < 8; i++) r[3'(i)] = d[IPI_T[3'(i)]];
    return r;
  endfunction

  // fK: left nibble XOR F(right nibble, subkey); right nibble passes through.
  function automatic logic [0:7] sdes_fk(input logic [0:7] d, input logic [0:7] sk);
    logic [0:7] ep;
    logic [0:3] s;
    logic [0:3] p;
    for (int i = 0; i < 8; i++) ep[3'(i)] = d[{1'b1, EP_T[3'(i)]}];
    ep = ep ^ sk;
    s[0:1] = S0_T[{ep[0], ep[3], ep[1], ep[2]}];
    s[2:3] = S1_T[{ep[4], ep[7], ep[5], ep[6]}];
    for (int i = 0; i < 4; i++) p[2'(i)] = s[P4_T[2'(i)]];
    return {d[0:3] ^ p, d[4:7]};
  endfunction

endpackage

// File: rtl/sdes_round.sv
// rtl/sdes_round.sv - one lane of combinational fK with optional nibble swap
//
// Ports: din    [0:7] lane state after IP (or after the first round)
//        subkey [0:7] K1 or K2, chosen by the engine
//        swap         1 = apply SW after fK
//        dout   [0:7] round result
module sdes_round
  import sdes_pkg::*;
(
  input  logic [0:7] din,
  input  logic [0:7] subkey,
  input  logic       swap,
  output logic [0:7] dout
);

  logic [0:7] f;

  assign f    = sdes_fk(din, subkey);
  assign dout = swap ? {f[4:7], f[0:3]} : f;

endmodule

// File: rtl/sdes_engine.sv
// rtl/sdes_engine.sv - multi-lane S-DES block engine, 3 cycles per block
//
// Optional feature: define SDES_CBC_EN for CBC chaining (adds the iv port).
// Ports: clk, rst_n (sync, active-low); key_load/key load K1,K2 in IDLE;
//        enc selects encrypt(1)/decrypt(0) per accepted block;
//        in_valid/in_ready/plaintext input block; out_valid/out_ready/ciphertext
//        result block (lane i at bits 8i..8i+7); busy = not IDLE (if BUSY_OUT);
//        iv per-lane chain seed (SDES_CBC_EN only).
module sdes_engine
  import sdes_pkg::*;
#(
  parameter int LANES    = 1,
  parameter int BUSY_OUT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_load,
  input  logic [0:9]           key,
  input  logic                 enc,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [0:8*LANES-1]   plaintext,
`ifdef SDES_CBC_EN
  input  logic [0:8*LANES-1]   iv,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [0:8*LANES-1]   ciphertext,
  output logic                 busy
);

  state_t     state, state_nxt;
  logic [0:7] k1, k2;
  logic       enc_q;
  logic       accept;
  logic       key_take;
  logic [0:7] round_key;

  // key_load masks in_ready so a block never meets a half-updated key.
  assign in_ready  = rst_n && !key_load &&
                     ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign key_take  = key_load && (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (BUSY_OUT != 0) && (state != IDLE);

  // Encrypt runs K1 then K2; decrypt runs K2 then K1.
  assign round_key = ((state == R1) == enc_q) ? k1 : k2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      k1    <= '0;
      k2    <= '0;
      enc_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (key_take) begin
        k1 <= sdes_k1(key);
        k2 <= sdes_k2(key);
      end
      if (accept) enc_q <= enc;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = R1;
      R1:      state_nxt = R2;
      R2:      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = accept ? R1 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [0:7] pt, lane_in, blk, rnd, res, ct;

    assign pt = plaintext[8*g +: 8];

`ifdef SDES_CBC_EN
    logic [0:7] chain, din_q;

    assign lane_in = enc ? (pt ^ chain) : pt;
    assign res     = enc_q ? sdes_ip_inv(rnd) : (sdes_ip_inv(rnd) ^ chain);

    // Decrypt chains on the ciphertext it consumed, so that block is kept
    // until R2 rather than overwriting chain while it is still needed.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        chain <= '0;
        din_q <= '0;
      end else begin
        if (key_take)           chain <= iv[8*g +: 8];
        else if (state == R2)   chain <= enc_q ? res : din_q;
        if (accept)             din_q <= pt;
      end
    end
`else
    assign lane_in = pt;
    assign res     = sdes_ip_inv(rnd);
`endif

    sdes_round u_round (
      .din    (blk),
      .subkey (round_key),
      .swap   (state == R1),
      .dout   (rnd)
    );

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        blk <= '0;
        ct  <= '0;
      end else begin
        if (accept)             blk <= sdes_ip(lane_in);
        else if (state == R1)   blk <= rnd;
        if (state == R2)        ct  <= res;
      end
    end

    assign ciphertext[8*g +: 8] = ct;
  end

endmodule

// File: tb/tb_sdes_engine.sv
// tb/tb_sdes_engine.sv - directed self-checking bench for sdes_engine (LANES=4)
module tb_sdes_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_load;
  logic [0:9]  key;
  logic        enc;
  logic        in_valid;
  logic        in_ready;
  logic [0:31] plaintext;
  logic        out_valid;
  logic        out_ready;
  logic [0:31] ciphertext;
  logic        busy;
`ifdef SDES_CBC_EN
  logic [0:31] iv;
`endif

  int checks   = 0;
  int failures = 0;

  localparam logic [0:9]  KEY_A = 10'b1010000010;
  localparam logic [0:31] PT_A  = {8'b10010111, 8'h00, 8'hFF, 8'b10010111};

  logic [0:31] cap;
  int          last_acc;
  int          n_acc;
  int          n_out;

  sdes_engine #(.LANES(4), .BUSY_OUT(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_load   (key_load),
    .key        (key),
    .enc        (enc),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
`ifdef SDES_CBC_EN
    .iv         (iv),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; key_load = 1'b0; key = '0; enc = 1'b0;
    in_valid = 1'b0; plaintext = '0; out_ready = 1'b0;
`ifdef SDES_CBC_EN
    iv = '0;
`endif
    step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ciphertext", ciphertext, 0);
    check("rst_in_ready_low", in_ready, 0);
    check("rst_k1", dut.k1, 0);
    check("rst_k2", dut.k2, 0);

    rst_n = 1'b1; #1;
    check("idle_in_ready", in_ready, 1);

    // key_load with a pending block: key taken, block not accepted
    key_load = 1'b1; key = KEY_A; in_valid = 1'b1; enc = 1'b1; plaintext = PT_A; #1;
    check("keyload_blocks_ready", in_ready, 0);
    step();
    check("no_accept_on_keyload", busy, 0);
    check("k1_derived", dut.k1, 8'b10100100);
    check("k2_derived", dut.k2, 8'b01000011);
    key_load = 1'b0; #1;
    check("ready_after_keyload", in_ready, 1);

    // encrypt: accept edge, then R1, R2, DONE on the third edge counting the accept
    step();
    in_valid = 1'b0; #1;
    check("r1_busy", busy, 1);
    check("r1_out_valid", out_valid, 0);
    step();
    check("r2_out_valid", out_valid, 0);
    step();
    check("done_out_valid", out_valid, 1);
    check("enc_lane0", ciphertext[0:7], 8'b00111000);
    check("enc_lane3", ciphertext[24:31], 8'b00111000);
    cap = ciphertext;

    // backpressure: output held, new block refused
    out_ready = 1'b0; in_valid = 1'b1; plaintext = '0;
    repeat (5) begin
      #1;
      check("bp_in_ready", in_ready, 0);
      step();
      check("bp_out_valid", out_valid, 1);
      check("bp_stable", ciphertext, cap);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("drain_to_idle", out_valid, 0);

    // decrypt, with a key_load in R1 that must be ignored
    key_load = 1'b1; key = KEY_A;
    step();
    key_load = 1'b0; enc = 1'b0; plaintext = cap; in_valid = 1'b1;
    step();
    in_valid = 1'b0; key_load = 1'b1; key = 10'b1111111111;
    step();
    key_load = 1'b0; #1;
    check("keyload_r1_ignored", dut.k1, 8'b10100100);
    step();
    check("dec_out_valid", out_valid, 1);
    check("dec_all_lanes", ciphertext, PT_A);
    step();

    // back-to-back with out_ready high
    key_load = 1'b1; key = KEY_A;
    step();
    key_load = 1'b0; enc = 1'b1; plaintext = {4{8'b10010111}}; out_ready = 1'b1;
    last_acc = -1; n_acc = 0; n_out = 0;
    for (int c = 0; c < 13; c++) begin
      in_valid = (c < 10);
      #1;
      if (in_valid && in_ready) begin
        if (last_acc >= 0) check("b2b_spacing", 64'(c - last_acc), 3);
        last_acc = c;
        n_acc++;
      end
      if (out_valid) begin
        n_out++;
`ifndef SDES_CBC_EN
        check("b2b_data", ciphertext, {4{8'b00111000}});
`endif
      end
      step();
    end
    check("b2b_accepts", 64'(n_acc), 4);
    check("b2b_outputs", 64'(n_out), 4);
    in_valid = 1'b0;
    step();

    // reset while in R2 discards the block
    enc = 1'b1; plaintext = PT_A; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("r2_busy", busy, 1);
    rst_n = 1'b0; #1;
    check("in_ready_rst_low", in_ready, 0);
    step();
    check("rst_r2_out_valid", out_valid, 0);
    check("rst_r2_busy", busy, 0);
    check("rst_r2_ciphertext", ciphertext, 0);
    rst_n = 1'b1;
    repeat (3) begin
      step();
      check("no_valid_after_rst", out_valid, 0);
    end

`ifdef SDES_CBC_EN
    iv = {8'h00, 8'h00, 8'h00, 8'h5A}; key_load = 1'b1; key = KEY_A;
    step();
    key_load = 1'b0; enc = 1'b1; plaintext = PT_A; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    check("cbc_iv_lanes_differ", 64'(ciphertext[0:7] != ciphertext[24:31]), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
